// File: rtl/sips4_pkg.sv
// Shared opcodes, ALU codes, flag indices, FSM states and the decoded control bundle for the
// SIPS4 sequencer.
package sips4_pkg;

  // Opcode is inst[15:11]; any opcode with inst[15]==OP_ALU is an ALU operation.
  localparam logic       OP_ALU = 1'b0;
  localparam logic [4:0] OP_JMP = 5'b10000;
  localparam logic [4:0] OP_BCC = 5'b10001;
  localparam logic [4:0] OP_JAL = 5'b10010;
  localparam logic [4:0] OP_LD  = 5'b10100;
  localparam logic [4:0] OP_ST  = 5'b10101;
  localparam logic [4:0] OP_IN  = 5'b10110;
  localparam logic [4:0] OP_OUT = 5'b10111;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;

  // Bit positions within the {N,Z,C,V} flag vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    StStop = 2'd0,
    StExec = 2'd1,
    StMemw = 2'd2,
    StHalt = 2'd3
  } state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       pc_src;
    logic       port_write;
    logic [3:0] alu_control;
    logic       pc_en;
    logic       is_alu;
    logic       is_load;
    logic       is_halt;
  } ctrl_t;

endpackage

// File: rtl/sips4_decoder.sv
// Combinational instruction decoder: inst (plus registered flags for BCC) -> control strobes,
// as seen in the EXEC cycle. State gating happens in the controller.
module sips4_decoder
  import sips4_pkg::*;
#(
  parameter logic [4:0] HALT_OP = 5'b11111
) (
  input  logic [15:0] inst,
  input  logic [3:0]  flags,
  output ctrl_t       ctrl
);

  logic [4:0] op;
  logic       unused_inst;

  assign op          = inst[15:11];
  // Immediate and write-address fields belong to the datapath.
  assign unused_inst = ^{inst[10:4], inst[2]};

  always_comb begin
    ctrl             = '0;
    ctrl.alu_control = ALU_ADD;
    if (op == HALT_OP) begin
      ctrl.is_halt = 1'b1;
    end else if (op[4] == OP_ALU) begin
      ctrl.alu_control = op[3:0];
      ctrl.alu_src     = inst[0];
      ctrl.reg_write   = 1'b1;
      ctrl.pc_en       = 1'b1;
      ctrl.is_alu      = 1'b1;
    end else begin
      case (op)
        OP_JMP: begin
          ctrl.alu_src = 1'b1;
          ctrl.pc_src  = 1'b1;
          ctrl.pc_en   = 1'b1;
        end
        OP_BCC: begin
          ctrl.alu_src = 1'b1;
          ctrl.pc_src  = flags[inst[1:0]] ^ inst[3];
          ctrl.pc_en   = 1'b1;
        end
        OP_JAL: begin
          ctrl.alu_src   = 1'b1;
          ctrl.pc_src    = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.pc_en     = 1'b1;
        end
        // First load cycle: address out, PC held, no write-back yet.
        OP_LD: begin
          ctrl.alu_src = inst[0];
          ctrl.is_load = 1'b1;
        end
        OP_ST: begin
          ctrl.alu_src   = inst[0];
          ctrl.mem_write = 1'b1;
          ctrl.pc_en     = 1'b1;
        end
        OP_IN: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.pc_en     = 1'b1;
        end
        OP_OUT: begin
          ctrl.alu_src    = 1'b1;
          ctrl.port_write = 1'b1;
          ctrl.pc_en      = 1'b1;
        end
        default: ctrl.pc_en = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/sips4_controller.sv
// SIPS4 sequencer: run/step/halt FSM, two-cycle load stall, NZCV flag register and state
// gating of the decoded control strobes.
module sips4_controller
  import sips4_pkg::*;
#(
  parameter bit         RESET_RUN = 1'b1,
  parameter logic [4:0] HALT_OP   = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic [15:0] inst,
  input  logic [3:0]  alu_flags,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        PCSrc,
  output logic        PortWrite,
  output logic [3:0]  ALUControl,
  output logic        pc_en,
  output logic [3:0]  flags,
  output logic        halted
);

  state_e     state_q, state_d;
  logic       stepping_q, stepping_d;
  logic [3:0] flags_q;
  ctrl_t      dec;
  ctrl_t      out;
  logic       keep_running;
  logic       unused_ctrl;

  sips4_decoder #(
    .HALT_OP(HALT_OP)
  ) u_decoder (
    .inst (inst),
    .flags(flags_q),
    .ctrl (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_RUN ? StExec : StStop;
      stepping_q <= 1'b0;
      flags_q    <= 4'h0;
    end else begin
      state_q    <= state_d;
      stepping_q <= stepping_d;
      if (state_q == StExec && dec.is_alu) begin
        flags_q <= alu_flags;
      end
    end
  end

  // A single-step instruction always retires into STOP, regardless of run.
  assign keep_running = run && !stepping_q;

  always_comb begin
    state_d    = state_q;
    stepping_d = stepping_q;
    unique case (state_q)
      StStop: begin
        if (run) begin
          state_d    = StExec;
          stepping_d = 1'b0;
        end else if (step) begin
          state_d    = StExec;
          stepping_d = 1'b1;
        end
      end
      StExec: begin
        if (dec.is_halt) begin
          state_d    = StHalt;
          stepping_d = 1'b0;
        end else if (dec.is_load) begin
          state_d = StMemw;
        end else begin
          state_d    = keep_running ? StExec : StStop;
          stepping_d = 1'b0;
        end
      end
      StMemw: begin
        state_d    = keep_running ? StExec : StStop;
        stepping_d = 1'b0;
      end
      StHalt: state_d = StHalt;
      default: state_d = StStop;
    endcase
  end

  // Reset gates strobes combinationally so an in-flight load never writes back.
  always_comb begin
    out             = '0;
    out.alu_control = ALU_ADD;
    if (rst_n) begin
      unique case (state_q)
        StExec: out = dec;
        StMemw: begin
          out.alu_src   = inst[0];
          out.reg_write = 1'b1;
          out.pc_en     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign unused_ctrl = ^{out.is_alu, out.is_load, out.is_halt};

  assign RegWrite   = out.reg_write;
  assign MemWrite   = out.mem_write;
  assign ALUSrc     = out.alu_src;
  assign PCSrc      = out.pc_src;
  assign PortWrite  = out.port_write;
  assign ALUControl = out.alu_control;
  assign pc_en      = out.pc_en;
  assign flags      = flags_q;
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_sips4_controller.sv
// Directed-vector bench for sips4_controller with hand-computed strobe/flag expectations.
module tb_sips4_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        step;
  logic [15:0] inst;
  logic [3:0]  alu_flags;
  logic        RegWrite, MemWrite, ALUSrc, PCSrc, PortWrite, pc_en, halted;
  logic [3:0]  ALUControl;
  logic [3:0]  flags;
  logic [5:0]  stb;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  sips4_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .inst      (inst),
    .alu_flags (alu_flags),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .ALUSrc    (ALUSrc),
    .PCSrc     (PCSrc),
    .PortWrite (PortWrite),
    .ALUControl(ALUControl),
    .pc_en     (pc_en),
    .flags     (flags),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // {RegWrite, MemWrite, ALUSrc, PCSrc, PortWrite, pc_en}
  assign stb = {RegWrite, MemWrite, ALUSrc, PCSrc, PortWrite, pc_en};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [5:0]  exp;
    string       tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h8000, 6'b001101, "jmp"};
    vecs[1] = '{16'h9000, 6'b101101, "jal"};
    vecs[2] = '{16'hA800, 6'b010001, "st"};
    vecs[3] = '{16'hB000, 6'b101001, "in"};
    vecs[4] = '{16'hB800, 6'b001011, "out"};
    vecs[5] = '{16'hC000, 6'b000001, "nop"};

    rst_n = 1'b0; run = 1'b1; step = 1'b0; inst = 16'h0033; alu_flags = 4'b0100;
    #12;
    check_eq("rst_stb", 16'(stb), 16'h0);
    check_eq("rst_flags", 16'(flags), 16'h0);
    check_eq("rst_halted", 16'(halted), 16'h0);

    // Test 1: first cycle after reset is EXEC, add-immediate
    rst_n = 1'b1;
    #1;
    check_eq("t1_stb", 16'(stb), 16'b101001);
    check_eq("t1_aluctl", 16'(ALUControl), 16'h0);
    cyc();
    check_eq("t1_flags", 16'(flags), 16'b0100);
    inst = 16'h3000; alu_flags = 4'b0001;
    #1;
    check_eq("alu_reg_stb", 16'(stb), 16'b100001);
    check_eq("alu_reg_ctl", 16'(ALUControl), 16'h6);
    cyc();
    check_eq("alu_reg_flags", 16'(flags), 16'b0001);

    // Test 2: two-cycle load
    inst = 16'hA003; alu_flags = 4'b1111;
    #1;
    check_eq("ld_c0", 16'(stb), 16'b001000);
    cyc();
    check_eq("ld_c1", 16'(stb), 16'b101001);
    cyc();
    check_eq("ld_flags_kept", 16'(flags), 16'b0001);
    inst = 16'hC000;
    #1;
    check_eq("ld_back_exec", 16'(stb), 16'b000001);

    // Test 3: BCC uses registered flags, not same-cycle alu_flags
    cyc();
    inst = 16'h0002; alu_flags = 4'b0100;
    #1;
    check_eq("t3_alu", 16'(stb), 16'b100001);
    cyc();
    inst = 16'h8802; alu_flags = 4'b0000;
    #1;
    check_eq("bcc_z_taken", 16'(stb), 16'b001101);
    inst = 16'h880A;
    #1;
    check_eq("bcc_nz_not", 16'(stb), 16'b001001);
    inst = 16'h8801;
    #1;
    check_eq("bcc_c_not", 16'(stb), 16'b001001);
    inst = 16'h8809;
    #1;
    check_eq("bcc_nc_taken", 16'(stb), 16'b001101);
    check_eq("bcc_flags", 16'(flags), 16'b0100);

    foreach (vecs[i]) begin
      inst = vecs[i].ins;
      #1;
      check_eq(vecs[i].tag, 16'(stb), 16'(vecs[i].exp));
    end

    // Test 4: stop and single-step
    cyc();
    inst = 16'hC000; run = 1'b0;
    #1;
    check_eq("stop_last_exec", 16'(stb), 16'b000001);
    cyc();
    check_eq("stopped", 16'(stb), 16'h0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check_eq("step_exec", 16'(stb), 16'b000001);
    cyc();
    check_eq("step_done", 16'(stb), 16'h0);
    cyc();
    check_eq("step_still_stop", 16'(stb), 16'h0);

    inst = 16'hA003; step = 1'b1;
    cyc();
    step = 1'b0;
    check_eq("step_ld_c0", 16'(stb), 16'b001000);
    cyc();
    check_eq("step_ld_c1", 16'(stb), 16'b101001);
    cyc();
    check_eq("step_ld_stop", 16'(stb), 16'h0);

    // run dropped during MEMW: load completes then STOP
    run = 1'b1;
    cyc();
    check_eq("run_ld_c0", 16'(stb), 16'b001000);
    cyc();
    run = 1'b0;
    check_eq("run_ld_c1", 16'(stb), 16'b101001);
    cyc();
    check_eq("run_ld_stop", 16'(stb), 16'h0);

    // Test 5: halt is sticky
    run = 1'b1; inst = 16'hF800;
    cyc();
    check_eq("halt_exec_stb", 16'(stb), 16'h0);
    check_eq("halt_exec_halted", 16'(halted), 16'h0);
    cyc();
    check_eq("halted", 16'(halted), 16'h1);
    inst = 16'hC000;
    for (int i = 0; i < 4; i++) begin
      run  = i[0];
      step = i[1];
      cyc();
      check_eq("halt_sticky", 16'(halted), 16'h1);
      check_eq("halt_pc_en", 16'(pc_en), 16'h0);
    end
    step = 1'b0; run = 1'b1;

    // Test 6: reset during MEMW
    rst_n = 1'b0;
    #1;
    check_eq("rst_unhalt", 16'(halted), 16'h0);
    cyc();
    rst_n = 1'b1; inst = 16'h0000; alu_flags = 4'b1111;
    #1;
    check_eq("t6_alu", 16'(stb), 16'b100001);
    cyc();
    check_eq("t6_flags", 16'(flags), 16'hF);
    inst = 16'hA000;
    #1;
    check_eq("t6_ld_c0", 16'(stb), 16'h0);
    cyc();
    check_eq("t6_ld_c1", 16'(stb), 16'b100001);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_stb", 16'(stb), 16'h0);
    check_eq("t6_rst_flags", 16'(flags), 16'h0);
    check_eq("t6_rst_halted", 16'(halted), 16'h0);
    cyc();
    rst_n = 1'b1; inst = 16'hC000;
    #1;
    check_eq("t6_no_wb0", 16'(RegWrite), 16'h0);
    cyc();
    check_eq("t6_no_wb1", 16'(RegWrite), 16'h0);
    check_eq("t6_pc_en", 16'(pc_en), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
